uart_tx_arbiter: RTL and testbench

Shares one UART transmitter between `NUM_REQ` byte-producing requesters using round-robin arbitration. It latches the granted byte and its baud selection, then generates the transmitter's start edge. It tracks the transmitter's ready line through the whole frame and reports completion to the owning requester. It sits between the statistics/readout producers and the single UART TX serializer on the board's TX pin.

---
 rtl/uart_tx_arbiter.sv | 144 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Round-robin arbiter that shares one UART transmitter between NUM_REQ
// byte producers. It latches the winning byte and baud select, raises
// tx_start, follows tx_ready through the frame and reports completion.

module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ID_W        = $clog2(NUM_REQ),
    parameter int ARM_TIMEOUT = 16,
    parameter int GAP_CYCLES  = 2
) (
    input  logic                   uart_clock,
    input  logic                   uart_reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [2*NUM_REQ-1:0]   req_freq,
    output logic [NUM_REQ-1:0]     req_ack,
    input  logic                   tx_ready,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    output logic [1:0]             tx_freq_control,
    output logic                   done,
    output logic [ID_W-1:0]        done_id,
    output logic                   busy,
    output logic                   err,
    input  logic                   err_clear
);

    localparam int CNT_W = $clog2(ARM_TIMEOUT + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARM  = 2'd1;
    localparam logic [1:0] ST_BUSY = 2'd2;
    localparam logic [1:0] ST_GAP  = 2'd3;

    logic [1:0]       state;
    logic [ID_W-1:0]  last_id;
    logic [ID_W-1:0]  cur_id;
    logic [CNT_W-1:0] arm_cnt;
    logic [GAP_W-1:0] gap_cnt;

    logic             grant_found;
    logic [ID_W-1:0]  grant_id;
    logic [ID_W-1:0]  cand;
    logic             timeout_hit;

    // Search the valid bits starting one past the last granted requester.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((int'(last_id) + k) % NUM_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_id    = cand;
            end
        end
    end

    // The transmitter never reacted to tx_start within the allowed window.
    always_comb begin
        timeout_hit = (state == ST_ARM) && tx_ready &&
                      (arm_cnt == CNT_W'(ARM_TIMEOUT - 1));
    end

    // Main sequencer: grant, arm the transmitter, track the frame, then gap.
    always_ff @(posedge uart_clock or negedge uart_reset) begin
        if (!uart_reset) begin
            state           <= ST_IDLE;
            last_id         <= ID_W'(NUM_REQ - 1);
            cur_id          <= '0;
            arm_cnt         <= '0;
            gap_cnt         <= '0;
            req_ack         <= '0;
            tx_start        <= 1'b0;
            tx_data         <= '0;
            tx_freq_control <= '0;
            done            <= 1'b0;
            done_id         <= '0;
            busy            <= 1'b0;
        end else begin
            req_ack <= '0;
            done    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (tx_ready && grant_found) begin
                        tx_data         <= req_data[int'(grant_id) * 8 +: 8];
                        tx_freq_control <= req_freq[int'(grant_id) * 2 +: 2];
                        cur_id          <= grant_id;
                        req_ack         <= NUM_REQ'(1) << grant_id;
                        tx_start        <= 1'b1;
                        busy            <= 1'b1;
                        arm_cnt         <= '0;
                        state           <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    if (!tx_ready) begin
                        tx_start <= 1'b0;
                        state    <= ST_BUSY;
                    end else if (timeout_hit) begin
                        tx_start <= 1'b0;
                        last_id  <= cur_id;
                        gap_cnt  <= '0;
                        state    <= ST_GAP;
                    end else begin
                        arm_cnt <= arm_cnt + CNT_W'(1);
                    end
                end
                ST_BUSY: begin
                    if (tx_ready) begin
                        done    <= 1'b1;
                        done_id <= cur_id;
                        last_id <= cur_id;
                        gap_cnt <= '0;
                        state   <= ST_GAP;
                    end
                end
                default: begin
                    if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
            endcase
        end
    end

    // Sticky timeout flag; a new timeout beats a simultaneous clear.
    always_ff @(posedge uart_clock or negedge uart_reset) begin
        if (!uart_reset) begin
            err <= 1'b0;
        end else if (timeout_hit) begin
            err <= 1'b1;
        end else if (err_clear) begin
            err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
// Drives the arbiter with a simple transmitter model and per-requester byte
// lists; expected frames go into a queue when presented and are popped on done.

module tb_uart_tx_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int ID_W       = 2;
    localparam int GAP_CYCLES = 2;
    localparam int FRAME_LEN  = 130;

    logic                 uart_clock;
    logic                 uart_reset;
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [2*NUM_REQ-1:0] req_freq;
    logic [NUM_REQ-1:0]   req_ack;
    logic                 tx_ready;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic [1:0]           tx_freq_control;
    logic                 done;
    logic [ID_W-1:0]      done_id;
    logic                 busy;
    logic                 err;
    logic                 err_clear;

    int check_count = 0;
    int fail_count  = 0;
    int done_seen   = 0;

    logic [11:0] exp_q[$];

    logic [7:0] pend_data [NUM_REQ][4];
    logic [1:0] pend_freq [NUM_REQ];
    int         pend_cnt  [NUM_REQ];
    int         pend_idx  [NUM_REQ];

    logic       m_ready;
    logic       m_prev;
    logic [1:0] m_phase;
    int         m_cnt;
    logic       force_low;
    logic       stuck_ready;
    logic [7:0] cap_data;
    logic [1:0] cap_freq;
    logic       hold_err;

    int         low_run;
    logic       seen_start;
    logic       prev_start_n;

    uart_tx_arbiter #(
        .NUM_REQ(NUM_REQ),
        .ID_W(ID_W),
        .ARM_TIMEOUT(16),
        .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .uart_clock(uart_clock),
        .uart_reset(uart_reset),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_freq(req_freq),
        .req_ack(req_ack),
        .tx_ready(tx_ready),
        .tx_start(tx_start),
        .tx_data(tx_data),
        .tx_freq_control(tx_freq_control),
        .done(done),
        .done_id(done_id),
        .busy(busy),
        .err(err),
        .err_clear(err_clear)
    );

    initial uart_clock = 1'b0;
    always #5 uart_clock = ~uart_clock;

    assign tx_ready = force_low ? 1'b0 : m_ready;

    // Transmitter model: ready falls two cycles after the start edge, stays low for a frame.
    always @(posedge uart_clock or negedge uart_reset) begin
        if (!uart_reset) begin
            m_ready <= 1'b1;
            m_prev  <= 1'b0;
            m_phase <= 2'd0;
            m_cnt   <= 0;
        end else begin
            m_prev <= tx_start;
            if (stuck_ready) begin
                m_ready <= 1'b1;
                m_phase <= 2'd0;
            end else begin
                case (m_phase)
                    2'd0: if (tx_start && !m_prev) m_phase <= 2'd1;
                    2'd1: begin
                        m_ready <= 1'b0;
                        m_cnt   <= FRAME_LEN;
                        m_phase <= 2'd2;
                    end
                    2'd2: begin
                        cap_data <= tx_data;
                        cap_freq <= tx_freq_control;
                        hold_err <= 1'b0;
                        m_cnt    <= m_cnt - 1;
                        m_phase  <= 2'd3;
                    end
                    default: begin
                        if (tx_data !== cap_data || tx_freq_control !== cap_freq)
                            hold_err <= 1'b1;
                        if (m_cnt <= 0) begin
                            m_ready <= 1'b1;
                            m_phase <= 2'd0;
                        end else begin
                            m_cnt <= m_cnt - 1;
                        end
                    end
                endcase
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Completion monitor: pops the scoreboard on done and watches the start gap.
    always @(negedge uart_clock) begin
        if (!uart_reset) begin
            low_run      = 0;
            seen_start   = 1'b0;
            prev_start_n = 1'b0;
        end else begin
            if (done) begin
                logic [11:0] e;
                done_seen++;
                checkOutput("done_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    checkOutput("done_id", 32'(done_id), 32'(e[11:10]));
                    checkOutput("frame_data", 32'(cap_data), 32'(e[7:0]));
                    checkOutput("frame_freq", 32'(cap_freq), 32'(e[9:8]));
                    checkOutput("data_hold", 32'(hold_err), 32'd0);
                end
            end
            if (tx_start && !prev_start_n) begin
                if (seen_start)
                    checkOutput("start_gap", 32'(low_run >= GAP_CYCLES), 32'd1);
                seen_start = 1'b1;
            end
            if (!tx_start) low_run++;
            else low_run = 0;
            prev_start_n = tx_start;
        end
    end

    task automatic applyStimulus(input int id, input logic [7:0] data,
                                 input logic [1:0] freq, input bit track);
        req_valid[id]        = 1'b1;
        req_data[id*8 +: 8]  = data;
        req_freq[id*2 +: 2]  = freq;
        if (track) exp_q.push_back({2'(id), freq, data});
    endtask

    // One cycle: advance to the sampling edge, then let acked requesters move on.
    task automatic tick();
        @(negedge uart_clock);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ack[i]) begin
                if (pend_idx[i] < pend_cnt[i]) begin
                    applyStimulus(i, pend_data[i][pend_idx[i]], pend_freq[i], 1'b1);
                    pend_idx[i]++;
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic checkResetValues(input string pfx);
        checkOutput({pfx, "_ack"},   32'(req_ack), 32'd0);
        checkOutput({pfx, "_start"}, 32'(tx_start), 32'd0);
        checkOutput({pfx, "_data"},  32'(tx_data), 32'd0);
        checkOutput({pfx, "_freq"},  32'(tx_freq_control), 32'd0);
        checkOutput({pfx, "_done"},  32'(done), 32'd0);
        checkOutput({pfx, "_id"},    32'(done_id), 32'd0);
        checkOutput({pfx, "_busy"},  32'(busy), 32'd0);
        checkOutput({pfx, "_err"},   32'(err), 32'd0);
    endtask

    task automatic doReset();
        uart_reset  = 1'b0;
        req_valid   = '0;
        req_data    = '0;
        req_freq    = '0;
        err_clear   = 1'b0;
        force_low   = 1'b0;
        stuck_ready = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pend_cnt[i] = 0;
            pend_idx[i] = 0;
        end
        tick();
        tick();
        uart_reset = 1'b1;
        tick();
    endtask

    task automatic waitDone(input int n);
        int target;
        target = done_seen + n;
        for (int c = 0; c < n * 400 && done_seen < target; c++) tick();
        checkOutput("done_count", 32'(done_seen), 32'(target));
    endtask

    task automatic waitIdle();
        for (int c = 0; c < 50 && busy; c++) tick();
        checkOutput("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int hi;
        int base;

        // Reset values
        uart_reset = 1'b0;
        #3;
        checkResetValues("reset");
        doReset();

        // Single request from requester 2
        applyStimulus(2, 8'hA5, 2'b11, 1'b1);
        tick();
        checkOutput("single_ack", 32'(req_ack), 32'b0100);
        checkOutput("single_start", 32'(tx_start), 32'd1);
        checkOutput("single_busy", 32'(busy), 32'd1);
        checkOutput("single_txdata", 32'(tx_data), 32'hA5);
        waitDone(1);
        waitIdle();

        // Contention between 0, 1, 3 with requester 0 re-requesting
        doReset();
        pend_data[0][0] = 8'h44;
        pend_freq[0]    = 2'b00;
        pend_cnt[0]     = 1;
        applyStimulus(0, 8'h11, 2'b00, 1'b1);
        applyStimulus(1, 8'h22, 2'b01, 1'b1);
        applyStimulus(3, 8'h33, 2'b10, 1'b1);
        waitDone(4);
        waitIdle();

        // Streaming from requester 1
        doReset();
        for (int b = 0; b < 3; b++) pend_data[1][b] = 8'(b + 1);
        pend_freq[1] = 2'b01;
        pend_cnt[1]  = 3;
        applyStimulus(1, 8'h00, 2'b01, 1'b1);
        waitDone(4);
        waitIdle();

        // Arm timeout with ready stuck high
        doReset();
        stuck_ready = 1'b1;
        base = done_seen;
        applyStimulus(2, 8'h5A, 2'b10, 1'b0);
        hi = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (tx_start) hi++;
            else if (hi > 0) break;
        end
        checkOutput("arm_len", 32'(hi), 32'd16);
        checkOutput("arm_err", 32'(err), 32'd1);
        waitIdle();
        checkOutput("arm_no_done", 32'(done_seen), 32'(base));
        checkOutput("err_sticky", 32'(err), 32'd1);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        checkOutput("err_cleared", 32'(err), 32'd0);
        stuck_ready = 1'b0;

        // Reset while in BUSY
        doReset();
        applyStimulus(0, 8'h77, 2'b01, 1'b0);
        for (int c = 0; c < 20 && tx_ready; c++) tick();
        tick();
        tick();
        checkOutput("midframe_busy", 32'(busy), 32'd1);
        #2;
        uart_reset = 1'b0;
        #1;
        checkResetValues("midreset");
        tick();
        tick();
        uart_reset = 1'b1;
        tick();
        applyStimulus(0, 8'h3C, 2'b10, 1'b1);
        tick();
        checkOutput("after_reset_ack", 32'(req_ack), 32'b0001);
        waitDone(1);
        waitIdle();

        // Ready held low blocks arbitration
        doReset();
        force_low = 1'b1;
        applyStimulus(0, 8'hC3, 2'b11, 1'b1);
        for (int c = 0; c < 5; c++) begin
            tick();
            checkOutput("blocked_ack", 32'(req_ack), 32'd0);
        end
        force_low = 1'b0;
        tick();
        checkOutput("unblocked_ack", 32'(req_ack), 32'b0001);
        waitDone(1);
        waitIdle();

        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

endmodule
